adaptive_alpha_controller: RTL and testbench

Upstream control stage for the dynamic noise-reduction IIR filter. It tracks the envelope of the incoming Q1.15 audio stream and drives the filter's alpha coefficient, using a gated attack/hold/release state machine. Quiet passages get heavy smoothing (small alpha); active signal passes nearly unfiltered (alpha ≈ 1.0). Alpha ramps between the two by a fixed step per sample to avoid zipper noise.

---
 rtl/adaptive_alpha_controller_if.sv | 24 ++
 rtl/adaptive_alpha_controller.sv | 157 +++++++++++++++
 tb/tb_adaptive_alpha_controller.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adaptive_alpha_controller_if.sv
// Sample/coefficient bundle between the audio source, the alpha controller and the IIR filter.
//   master: drives sample_valid, x_in, threshold; observes alpha, alpha_valid, envelope, gate_open
//   slave : the controller side (inputs and outputs reversed)
interface adaptive_alpha_controller_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    sample_valid;
  logic signed [WIDTH-1:0] x_in;
  logic        [WIDTH-1:0] threshold;
  logic signed [WIDTH-1:0] alpha;
  logic                    alpha_valid;
  logic        [WIDTH-1:0] envelope;
  logic                    gate_open;

  modport master (
    output sample_valid, x_in, threshold,
    input  alpha, alpha_valid, envelope, gate_open
  );

  modport slave (
    input  sample_valid, x_in, threshold,
    output alpha, alpha_valid, envelope, gate_open
  );
endinterface

// File: rtl/adaptive_alpha_controller.sv
// Envelope-gated alpha controller for the noise-reduction IIR filter.
// Tracks the Q1.15 input envelope (fast attack, slow release) and ramps alpha between
// ALPHA_MIN (gate closed, heavy smoothing) and ALPHA_MAX (gate open) by ALPHA_STEP per
// accepted sample, with a hold period before closing.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of adaptive_alpha_controller_if
//              (sample_valid/x_in/threshold in; alpha/alpha_valid/envelope/gate_open out)
module adaptive_alpha_controller #(
  parameter int unsigned             WIDTH         = 16,
  parameter int unsigned             ATTACK_SHIFT  = 2,
  parameter int unsigned             RELEASE_SHIFT = 6,
  parameter int unsigned             HOLD_SAMPLES  = 256,
  parameter logic signed [WIDTH-1:0] ALPHA_MIN     = 16'sd3277,
  parameter logic signed [WIDTH-1:0] ALPHA_MAX     = 16'sd32767,
  parameter logic signed [WIDTH-1:0] ALPHA_STEP    = 16'sd1024
) (
  input logic                        clk,
  input logic                        reset_n,
  adaptive_alpha_controller_if.slave bus
);

  localparam int unsigned        HoldW    = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam logic [HoldW-1:0]   HoldLoad = HoldW'(HOLD_SAMPLES - 1);
  localparam logic [WIDTH-1:0]   EnvMax   = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {StClosed, StOpening, StOpen, StHold, StClosing} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] alpha_q, alpha_d;
  logic        [WIDTH-1:0] env_q, env_d;
  logic        [HoldW-1:0] hold_q, hold_d;
  logic                    valid_q;

  // Sign bit of threshold carries no meaning.
  logic unused_thr_msb;
  assign unused_thr_msb = bus.threshold[WIDTH-1];

  // ---------------------------------------------------------------------------------------
  // Envelope follower (all arithmetic one bit wider than the sample)
  // ---------------------------------------------------------------------------------------
  logic signed [WIDTH:0] x_ext, mag_raw, mag, env_ext, diff, env_sum;
  logic        [WIDTH-1:0] env_next;
  logic                    above;

  always_comb begin
    x_ext   = {bus.x_in[WIDTH-1], bus.x_in};
    mag_raw = x_ext[WIDTH] ? -x_ext : x_ext;
    // Only |-32768| sets bit WIDTH-1; saturate it to full-scale positive.
    mag     = mag_raw[WIDTH-1] ? {2'b00, {(WIDTH-1){1'b1}}} : mag_raw;
    env_ext = {1'b0, env_q};
    diff    = mag - env_ext;
    if (!diff[WIDTH] && (diff != '0)) begin
      env_sum = env_ext + (diff >>> ATTACK_SHIFT);
    end else begin
      env_sum = env_ext + (diff >>> RELEASE_SHIFT);
    end
    if (env_sum[WIDTH]) begin
      env_next = '0;
    end else if (env_sum[WIDTH-1]) begin
      env_next = EnvMax;
    end else begin
      env_next = env_sum[WIDTH-1:0];
    end
    above = (env_next >= {1'b0, bus.threshold[WIDTH-2:0]});
  end

  // ---------------------------------------------------------------------------------------
  // Saturating alpha ramp
  // ---------------------------------------------------------------------------------------
  logic signed [WIDTH:0]   alpha_ext, step_ext, max_ext, min_ext, alpha_up, alpha_dn;
  logic signed [WIDTH-1:0] rise_alpha, fall_alpha;
  state_e                  rise_state, fall_state;

  always_comb begin
    alpha_ext  = {alpha_q[WIDTH-1], alpha_q};
    step_ext   = {ALPHA_STEP[WIDTH-1], ALPHA_STEP};
    max_ext    = {ALPHA_MAX[WIDTH-1], ALPHA_MAX};
    min_ext    = {ALPHA_MIN[WIDTH-1], ALPHA_MIN};
    alpha_up   = alpha_ext + step_ext;
    alpha_dn   = alpha_ext - step_ext;
    rise_alpha = (alpha_up >= max_ext) ? ALPHA_MAX : alpha_up[WIDTH-1:0];
    fall_alpha = (alpha_dn <= min_ext) ? ALPHA_MIN : alpha_dn[WIDTH-1:0];
    rise_state = (rise_alpha == ALPHA_MAX) ? StOpen : StOpening;
    fall_state = (fall_alpha == ALPHA_MIN) ? StClosed : StClosing;
  end

  // ---------------------------------------------------------------------------------------
  // Gate state machine; advances only on accepted samples
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    alpha_d = alpha_q;
    env_d   = env_q;
    hold_d  = hold_q;
    if (bus.sample_valid) begin
      env_d = env_next;
      unique case (state_q)
        StClosed, StOpening, StClosing: begin
          // Rising from CLOSING reverses a close mid-ramp.
          if (above) begin
            alpha_d = rise_alpha;
            state_d = rise_state;
          end else if (state_q != StClosed) begin
            alpha_d = fall_alpha;
            state_d = fall_state;
          end
        end
        StOpen: begin
          if (!above) begin
            state_d = StHold;
            hold_d  = HoldLoad;
          end
        end
        StHold: begin
          if (above) begin
            state_d = StOpen;
            hold_d  = '0;
          end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else begin
            alpha_d = fall_alpha;
            state_d = fall_state;
          end
        end
        default: begin
          state_d = StClosed;
          alpha_d = ALPHA_MIN;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StClosed;
      alpha_q <= ALPHA_MIN;
      env_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alpha_q <= alpha_d;
      env_q   <= env_d;
      hold_q  <= hold_d;
      valid_q <= bus.sample_valid;
    end
  end

  assign bus.alpha       = alpha_q;
  assign bus.alpha_valid = valid_q;
  assign bus.envelope    = env_q;
  assign bus.gate_open   = (state_q == StOpening) || (state_q == StOpen) || (state_q == StHold);

endmodule

// File: tb/tb_adaptive_alpha_controller.sv
// Self-checking bench for adaptive_alpha_controller: directed scenarios plus randomized
// loud/quiet bursts with idle gaps, checked against an integer reference model.
module tb_adaptive_alpha_controller;

  localparam int ATK = 2;
  localparam int REL = 6;
  localparam int HOLD = 256;
  localparam int AMIN = 3277;
  localparam int AMAX = 32767;
  localparam int STEP = 1024;

  localparam int M_CLOSED = 0;
  localparam int M_OPENING = 1;
  localparam int M_OPEN = 2;
  localparam int M_HOLD = 3;
  localparam int M_CLOSING = 4;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  adaptive_alpha_controller_if #(.WIDTH(16)) bus ();

  adaptive_alpha_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int m_env, m_alpha, m_hold, m_st;
  bit m_above;

  function automatic void model_reset();
    m_env = 0; m_alpha = AMIN; m_hold = 0; m_st = M_CLOSED; m_above = 1'b0;
  endfunction

  function automatic bit model_gate();
    return (m_st == M_OPENING) || (m_st == M_OPEN) || (m_st == M_HOLD);
  endfunction

  function automatic void model_rise();
    m_alpha = (m_alpha + STEP > AMAX) ? AMAX : m_alpha + STEP;
    m_st = (m_alpha == AMAX) ? M_OPEN : M_OPENING;
  endfunction

  function automatic void model_fall();
    m_alpha = (m_alpha - STEP < AMIN) ? AMIN : m_alpha - STEP;
    m_st = (m_alpha == AMIN) ? M_CLOSED : M_CLOSING;
  endfunction

  function automatic void model_step(input int x, input int thr);
    int mag, diff;
    mag = (x < 0) ? -x : x;
    if (mag > 32767) mag = 32767;
    diff = mag - m_env;
    if (diff > 0) m_env = m_env + (diff >>> ATK);
    else          m_env = m_env + (diff >>> REL);
    if (m_env < 0) m_env = 0;
    if (m_env > 32767) m_env = 32767;
    m_above = (m_env >= (thr % 32768));
    case (m_st)
      M_CLOSED, M_OPENING, M_CLOSING: begin
        if (m_above) model_rise();
        else if (m_st != M_CLOSED) model_fall();
      end
      M_OPEN: if (!m_above) begin m_st = M_HOLD; m_hold = HOLD - 1; end
      M_HOLD: begin
        if (m_above) begin m_st = M_OPEN; m_hold = 0; end
        else if (m_hold > 0) m_hold = m_hold - 1;
        else model_fall();
      end
      default: ;
    endcase
  endfunction

  // Drives one accepted sample; returns #1 after the capturing edge.
  task automatic send(input int x, input int thr);
    @(negedge clk);
    bus.sample_valid = 1'b1;
    bus.x_in = x[15:0];
    bus.threshold = thr[15:0];
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    model_step(x, thr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    int pulses;
    int changed;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #2;
    n_checks++;
    if (bus.alpha !== 16'sd3277) $display("FAIL reset_alpha: got %0d want 3277", bus.alpha);
    else n_pass++;
    n_checks++;
    if (bus.envelope !== 16'd0) $display("FAIL reset_env: got %0d want 0", bus.envelope);
    else n_pass++;
    n_checks++;
    if (bus.gate_open !== 1'b0) $display("FAIL reset_gate: got %b want 0", bus.gate_open);
    else n_pass++;
    n_checks++;
    if (bus.alpha_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.alpha_valid);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    pulses = 0;
    changed = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.alpha_valid !== 1'b0) pulses++;
      if (bus.alpha !== 16'sd3277 || bus.envelope !== 16'd0 || bus.gate_open !== 1'b0) changed++;
    end
    n_checks++;
    if (pulses != 0) $display("FAIL idle_pulses: got %0d pulses want 0", pulses);
    else n_pass++;
    n_checks++;
    if (changed != 0) $display("FAIL idle_outputs: %0d cycles differed from reset values", changed);
    else n_pass++;
  endtask

  task automatic test_attack();
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      send(16384, 8192);
      if (i == 1) begin
        n_checks++;
        if (bus.envelope !== 16'd4096) $display("FAIL attack_env1: got %0d want 4096", bus.envelope);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if (bus.envelope !== 16'd7168) $display("FAIL attack_env2: got %0d want 7168", bus.envelope);
        else n_pass++;
        n_checks++;
        if (bus.gate_open !== 1'b0) $display("FAIL attack_gate2: got %b want 0", bus.gate_open);
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (bus.envelope !== 16'd9472) $display("FAIL attack_env3: got %0d want 9472", bus.envelope);
        else n_pass++;
        n_checks++;
        if (bus.gate_open !== 1'b1) $display("FAIL attack_gate3: got %b want 1", bus.gate_open);
        else n_pass++;
        n_checks++;
        if (bus.alpha !== 16'sd4301) $display("FAIL attack_alpha3: got %0d want 4301", bus.alpha);
        else n_pass++;
      end
      if (i == 30) begin
        n_checks++;
        if (bus.alpha !== 16'sd31949) $display("FAIL attack_alpha30: got %0d want 31949", bus.alpha);
        else n_pass++;
      end
      if (i == 31) begin
        n_checks++;
        if (bus.alpha !== 16'sd32767) $display("FAIL attack_alpha31: got %0d want 32767", bus.alpha);
        else n_pass++;
      end
      n_checks++;
      if (bus.alpha !== m_alpha[15:0] || bus.envelope !== m_env[15:0] ||
          bus.gate_open !== model_gate()) begin
        $display("FAIL attack_model[%0d]: got alpha=%0d env=%0d gate=%b want %0d %0d %b",
                 i, bus.alpha, bus.envelope, bus.gate_open, m_alpha, m_env, model_gate());
      end else n_pass++;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send(-32768, 16000);
    n_checks++;
    if (bus.envelope !== 16'd8191) $display("FAIL sat_env: got %0d want 8191", bus.envelope);
    else n_pass++;
    n_checks++;
    if (bus.alpha_valid !== 1'b1) $display("FAIL sat_valid_hi: got %b want 1", bus.alpha_valid);
    else n_pass++;
    n_checks++;
    if (bus.alpha !== 16'sd3277) $display("FAIL sat_alpha: got %0d want 3277", bus.alpha);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.alpha_valid !== 1'b0) $display("FAIL sat_valid_lo: got %b want 0", bus.alpha_valid);
    else n_pass++;
  endtask

  // From OPEN, feeds silence and reports on which below-threshold sample alpha first drops.
  task automatic drop_until_fall(input string tag, output int first_dec);
    int below;
    int gate_bad;
    below = 0;
    gate_bad = 0;
    first_dec = -1;
    for (int i = 0; i < 1000 && first_dec < 0; i++) begin
      send(0, 8192);
      if (!m_above) below++;
      if (bus.alpha !== 16'sd32767) first_dec = below;
      else if (below > 0 && bus.gate_open !== 1'b1) gate_bad++;
    end
    n_checks++;
    if (gate_bad != 0) $display("FAIL %s_hold_gate: %0d hold samples with gate low", tag, gate_bad);
    else n_pass++;
    n_checks++;
    if (first_dec != 257) $display("FAIL %s_first_dec: got sample %0d want 257", tag, first_dec);
    else n_pass++;
    n_checks++;
    if (bus.alpha !== 16'sd31743) $display("FAIL %s_dec_alpha: got %0d want 31743", tag, bus.alpha);
    else n_pass++;
  endtask

  task automatic test_hold_close();
    int first_dec;
    int steps;
    do_reset();
    for (int i = 0; i < 40; i++) send(16384, 8192);
    n_checks++;
    if (bus.alpha !== 16'sd32767 || bus.gate_open !== 1'b1)
      $display("FAIL hc_open: got alpha=%0d gate=%b want 32767 1", bus.alpha, bus.gate_open);
    else n_pass++;
    drop_until_fall("hc", first_dec);
    steps = 1;
    for (int i = 0; i < 100 && bus.alpha !== 16'sd3277; i++) begin
      send(0, 8192);
      steps++;
    end
    n_checks++;
    if (steps != 29) $display("FAIL hc_close_steps: got %0d want 29", steps);
    else n_pass++;
    n_checks++;
    if (bus.gate_open !== 1'b0 || bus.alpha !== 16'sd3277)
      $display("FAIL hc_closed: got alpha=%0d gate=%b want 3277 0", bus.alpha, bus.gate_open);
    else n_pass++;
    n_checks++;
    if (m_st != M_CLOSED) $display("FAIL hc_model_state: got %0d want %0d", m_st, M_CLOSED);
    else n_pass++;
  endtask

  task automatic test_retrigger_reversal();
    int below;
    int first_dec;
    do_reset();
    for (int i = 0; i < 40; i++) send(16384, 8192);
    below = 0;
    for (int i = 0; i < 1000 && below < 10; i++) begin
      send(0, 8192);
      if (!m_above) below++;
    end
    n_checks++;
    if (bus.gate_open !== 1'b1 || bus.alpha !== 16'sd32767)
      $display("FAIL rt_in_hold: got gate=%b alpha=%0d want 1 32767", bus.gate_open, bus.alpha);
    else n_pass++;
    send(32767, 8192);
    n_checks++;
    if (bus.gate_open !== 1'b1 || bus.alpha !== 16'sd32767 || m_st != M_OPEN)
      $display("FAIL rt_retrigger: got gate=%b alpha=%0d want 1 32767", bus.gate_open, bus.alpha);
    else n_pass++;
    drop_until_fall("rt", first_dec);
    for (int i = 0; i < 100 && bus.alpha !== 16'sd20479; i++) send(0, 8192);
    n_checks++;
    if (bus.alpha !== 16'sd20479 || bus.gate_open !== 1'b0)
      $display("FAIL rv_mid_close: got alpha=%0d gate=%b want 20479 0", bus.alpha, bus.gate_open);
    else n_pass++;
    send(32767, 4096);
    n_checks++;
    if (bus.alpha !== 16'sd21503) $display("FAIL rv_alpha: got %0d want 21503", bus.alpha);
    else n_pass++;
    n_checks++;
    if (bus.gate_open !== 1'b1) $display("FAIL rv_gate: got %b want 1", bus.gate_open);
    else n_pass++;
  endtask

  task automatic test_threshold_zero();
    do_reset();
    send(0, 0);
    n_checks++;
    if (bus.alpha !== 16'sd4301 || bus.gate_open !== 1'b1 || bus.envelope !== 16'd0)
      $display("FAIL thr0_first: got alpha=%0d gate=%b env=%0d want 4301 1 0",
               bus.alpha, bus.gate_open, bus.envelope);
    else n_pass++;
    send(0, 32768);
    n_checks++;
    if (bus.alpha !== 16'sd5325) $display("FAIL thr_msb_ignored: got %0d want 5325", bus.alpha);
    else n_pass++;
  endtask

  task automatic test_reset_mid_ramp();
    do_reset();
    for (int i = 0; i < 5; i++) send(16384, 0);
    n_checks++;
    if (bus.alpha !== 16'sd8397) $display("FAIL mid_ramp_alpha: got %0d want 8397", bus.alpha);
    else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.alpha !== 16'sd3277 || bus.gate_open !== 1'b0 || bus.envelope !== 16'd0)
      $display("FAIL async_reset: got alpha=%0d gate=%b env=%0d want 3277 0 0",
               bus.alpha, bus.gate_open, bus.envelope);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    send(0, 0);
    n_checks++;
    if (bus.alpha !== 16'sd4301 || bus.envelope !== 16'd0)
      $display("FAIL post_reset_sample: got alpha=%0d env=%0d want 4301 0", bus.alpha, bus.envelope);
    else n_pass++;
  endtask

  task automatic test_random_gaps();
    logic [15:0] a0, e0;
    logic        g0;
    int          x, thr, len, gap;
    bit          loud;
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      loud = (blk % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      len = $urandom_range(30, 450);
      thr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(2000, 10000);
      if ($urandom_range(0, 1) == 1) thr = thr + 32768;
      for (int s = 0; s < len; s++) begin
        gap = $urandom_range(0, 3);
        a0 = bus.alpha;
        e0 = bus.envelope;
        g0 = bus.gate_open;
        for (int c = 0; c < gap; c++) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (bus.alpha !== a0 || bus.envelope !== e0 || bus.gate_open !== g0 ||
              bus.alpha_valid !== 1'b0)
            $display("FAIL gap_frozen: got alpha=%0d env=%0d gate=%b valid=%b want %0d %0d %b 0",
                     bus.alpha, bus.envelope, bus.gate_open, bus.alpha_valid, a0, e0, g0);
          else n_pass++;
        end
        if (loud) begin
          x = ($urandom_range(0, 49) == 0) ? -32768 : $urandom_range(12000, 32767);
          if ($urandom_range(0, 1) == 1) x = -x;
        end else begin
          x = $urandom_range(0, 600) - 300;
        end
        send(x, thr);
        n_checks++;
        if (bus.alpha !== m_alpha[15:0] || bus.envelope !== m_env[15:0] ||
            bus.gate_open !== model_gate() || bus.alpha_valid !== 1'b1)
          $display("FAIL rand_sample: x=%0d got alpha=%0d env=%0d gate=%b valid=%b want %0d %0d %b 1",
                   x, bus.alpha, bus.envelope, bus.gate_open, bus.alpha_valid,
                   m_alpha, m_env, model_gate());
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    bus.sample_valid = 1'b0;
    bus.x_in = '0;
    bus.threshold = '0;
    model_reset();
    test_reset();
    test_attack();
    test_saturation();
    test_hold_close();
    test_retrigger_reversal();
    test_threshold_zero();
    test_reset_mid_ramp();
    test_random_gaps();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
